// File: rtl/stage_rr_arbiter.sv
// Round-robin front end that shares one single-entry processing stage among NUM_REQ requesters.
// Latency: accept at edge T, stage_valid from T, tagged out_valid after T+2 with a 1-cycle stage; >=4 cycles/txn.
// Backpressure: stalls in ISSUE on stage_i_ready, in WAIT on stage_r_ready, in DRAIN on out_ready; no grant while busy.
module stage_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          stage_valid,
  output logic [DATA_WIDTH-1:0]         stage_data,
  input  logic                          stage_i_ready,
  input  logic                          stage_r_ready,
  input  logic [DATA_WIDTH-1:0]         stage_result,
  output logic                          result_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ID_WIDTH-1:0]           out_id,
  input  logic                          out_ready,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          done_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     last_grant_q, last_grant_d;
  logic [ID_WIDTH-1:0]     grant_id_q, grant_id_d;
  logic                    stage_valid_q, stage_valid_d;
  logic [DATA_WIDTH-1:0]   stage_data_q, stage_data_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [ID_WIDTH-1:0]     out_id_q, out_id_d;
  logic [CNT_WIDTH-1:0]    done_count_q, done_count_d;

  logic                    win_found;
  logic [ID_WIDTH-1:0]     win_id;
  logic [ID_WIDTH-1:0]     scan_id;

  // Pick the first valid requester after last_grant, wrapping modulo NUM_REQ.
  // last_grant itself is scanned last, so it only wins again when it is alone.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_id   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      scan_id = ID_WIDTH'((int'(last_grant_q) + i) % NUM_REQ);
      if (!win_found && req_valid[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
  end

  // Handshake strobes decoded from the current state.
  always_comb begin
    req_ready    = '0;
    result_ready = 1'b0;
    if (state_q == S_IDLE && win_found) begin
      req_ready[win_id] = 1'b1;
    end
    if (state_q == S_WAIT) begin
      result_ready = 1'b1;
    end
  end

  // Next-state and registered-output logic for the one-transaction-at-a-time sequencer.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    stage_valid_d = stage_valid_q;
    stage_data_d  = stage_data_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_id_d      = out_id_q;
    done_count_d  = done_count_q;
    unique case (state_q)
      S_IDLE: begin
        // A winner always has req_valid high and req_ready high, so it transfers now.
        if (win_found) begin
          stage_data_d  = req_data[win_id*DATA_WIDTH +: DATA_WIDTH];
          grant_id_d    = win_id;
          last_grant_d  = win_id;
          stage_valid_d = 1'b1;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (stage_i_ready) begin
          stage_valid_d = 1'b0;
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        if (stage_r_ready) begin
          out_data_d  = stage_result;
          out_id_d    = grant_id_q;
          out_valid_d = 1'b1;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          out_valid_d  = 1'b0;
          done_count_d = done_count_q + CNT_WIDTH'(1);
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      last_grant_q  <= ID_WIDTH'(NUM_REQ - 1);
      grant_id_q    <= '0;
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_id_q      <= '0;
      done_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      stage_valid_q <= stage_valid_d;
      stage_data_q  <= stage_data_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_id_q      <= out_id_d;
      done_count_q  <= done_count_d;
    end
  end

  assign stage_valid = stage_valid_q;
  assign stage_data  = stage_data_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_id      = out_id_q;
  assign done_count  = done_count_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/stage_rr_arbiter.md
Name: stage_rr_arbiter

Overview:
- Shares one single-entry processing stage among NUM_REQ upstream requesters using round-robin arbitration.
- The processing stage has ready/valid handshakes in both directions: an issue side and a result side.
- Sequences exactly one transaction at a time: accept from one requester, issue to the stage, collect the result, deliver it downstream tagged with the requester id.
- Sits between the per-lane image pipelines and the shared processing stage.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, payload width in bits.
- ID_WIDTH, 2, width of the requester id; must equal clog2(NUM_REQ).
- CNT_WIDTH, 16, width of the completed-transaction counter.

Ports:
- clock  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester "data available".
- req_data  in  NUM_REQ*DATA_WIDTH  packed payloads; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant/accept.
- stage_valid  out  1  issue payload valid to the stage.
- stage_data  out  DATA_WIDTH  issue payload.
- stage_i_ready  in  1  stage ready to receive.
- stage_r_ready  in  1  stage has a result.
- stage_result  in  DATA_WIDTH  result payload.
- result_ready  out  1  arbiter accepts the result.
- out_valid  out  1  tagged result valid downstream.
- out_data  out  DATA_WIDTH  result payload.
- out_id  out  ID_WIDTH  id of the originating requester.
- out_ready  in  1  downstream accepts.
- busy  out  1  high when state is not IDLE.
- done_count  out  CNT_WIDTH  completed transactions, wraps modulo 2^CNT_WIDTH.

Behaviour:

Reset (asynchronous, active-high):
- state=IDLE, last_grant=NUM_REQ-1, so requester 0 has top priority first.
- All registered outputs are 0: stage_valid, stage_data, out_valid, out_data, out_id, done_count.
- Reset asserted mid-transaction aborts it with no output. The in-flight stage result is not consumed; the stage owner must reset the stage in the same reset domain.

Handshakes:
- A transfer occurs on a rising edge where valid and ready are both 1.
- All handshakes follow this rule: req_valid/req_ready, stage_valid/stage_i_ready, stage_r_ready/result_ready, out_valid/out_ready.

State machine (one-hot or binary, implementer's choice):

IDLE:
- req_ready is combinational and one-hot on the winner: the first k with req_valid[k]=1, scanning k = last_grant+1, +2, … modulo NUM_REQ.
- All zeros if no request.
- On transfer: latch the winner's data into stage_data, the id into grant_id, set last_grant=winner, set stage_valid=1, go to ISSUE.

ISSUE:
- Hold stage_valid=1 and stage_data stable.
- On a stage_i_ready edge: stage_valid=0, go to WAIT.

WAIT:
- result_ready=1 (combinational on state).
- On a stage_r_ready edge: out_data=stage_result, out_id=grant_id, out_valid=1, go to DRAIN.

DRAIN:
- Hold out_valid, out_data and out_id stable.
- On an out_ready edge: out_valid=0, done_count+1, go to IDLE.

Default outputs:
- req_ready=0 outside IDLE; result_ready=0 outside WAIT.

Latency and throughput:
- Request accepted at edge T gives stage_valid=1 from T.
- With stage and downstream always ready and a 1-cycle stage, out_valid is asserted after edge T+2 (ISSUE → WAIT → DRAIN).
- The next request is accepted at T+4 at the earliest.
- Throughput is 1 transaction per ≥4 cycles.

Boundary conditions:
- A requester dropping req_valid after acceptance has no effect; the payload is already latched.
- A requester dropping req_valid before acceptance is never granted.
- stage_r_ready asserted in ISSUE is ignored until WAIT.
- last_grant updates only on acceptance; idle cycles do not rotate priority.
- The same requester is never granted twice in a row while any other requester is valid.
- A lone requester may be granted back-to-back.
- done_count wraps from 2^CNT_WIDTH-1 to 0.

Test Plan:
1. Reset, then req_valid=4'b0001, data0=8'h10, stage echoes +1 in 1 cycle, out_ready=1 → out_data=8'h11, out_id=0, done_count=1, first req_ready[0] at the first IDLE cycle.
2. req_valid=4'b1111 held constantly, stage and downstream always ready → grant order 0,1,2,3,0,…; out_id sequence 0,1,2,3,0; one completion every 4 cycles.
3. After granting 2, req_valid=4'b0101 → next grant is 0 (wrap-around), then 2.
4. stage_i_ready low for 5 cycles in ISSUE → stage_valid and stage_data stable for all 5 cycles; req_ready=0 throughout; no second acceptance.
5. out_ready low for 3 cycles in DRAIN with data 8'hA5, id 3 → out_valid, out_data and out_id held; done_count increments only on the accept edge.
6. Async reset pulse mid-WAIT → all outputs 0 immediately without a clock edge; state=IDLE; after release, requester 0 wins against req_valid=4'b1001.
